// File: rtl/vga_sel_pkg.sv
// vga_sel_pkg: shared types and constants for the VGA pattern selector
package vga_sel_pkg;
  localparam int IDX_W = 4;
  localparam logic [63:0] BLACK = '0;
  typedef enum logic [1:0] {SHOW, PEND, BLANK} state_t;
endpackage

// File: rtl/vga_pattern_sel_if.sv
// vga_pattern_sel_if: pixel, request and output signals of the pattern selector
interface vga_pattern_sel_if #(
  parameter int NUM_SRC = 6,
  parameter int DATA_W = 16,
  parameter int XW = 10,
  parameter int YW = 10
);
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic pix_valid;
  logic [NUM_SRC-1:0] sel_onehot;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic auto_en;
  logic [DATA_W-1:0] pix_data;
  logic [vga_sel_pkg::IDX_W-1:0] cur_idx;
  logic sel_err;
  modport master (
    output pix_x, pix_y, pix_valid, sel_onehot, src_data, auto_en,
    input pix_data, cur_idx, sel_err
  );
  modport slave (
    input pix_x, pix_y, pix_valid, sel_onehot, src_data, auto_en,
    output pix_data, cur_idx, sel_err
  );
endinterface

// File: rtl/vga_onehot_enc.sv
// vga_onehot_enc: one-hot to index encoder; ok for exactly one bit, multi for more
module vga_onehot_enc
  import vga_sel_pkg::*;
#(
  parameter int N = 6
) (
  input  logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             ok,
  output logic             multi
);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (onehot[i]) idx = IDX_W'(i);
    ok = $countones(onehot) == 1;
    multi = $countones(onehot) > 1;
  end
endmodule

// File: rtl/vga_pattern_sel.sv
// vga_pattern_sel: frame-synchronous N-source pattern mux with auto-cycle.
// Define VGA_PATTERN_SEL_BLANK_EN to insert one black frame on every source change.
module vga_pattern_sel
  import vga_sel_pkg::*;
#(
  parameter int NUM_SRC = 6,
  parameter int DATA_W = 16,
  parameter int XW = 10,
  parameter int YW = 10,
  parameter int AUTO_FRAMES = 60,
  parameter int DEFAULT_IDX = 0
) (
  input logic clk,
  input logic rst,
  vga_pattern_sel_if.slave bus
);
  localparam int CW = $clog2(AUTO_FRAMES) + 1;
  state_t state_q, state_d;
  logic [IDX_W-1:0] cur_idx_q, pend_idx_q, req_idx, npidx, eff_idx, nxt_idx, auto_idx;
  logic pend_q, pend_d, req_ok, req_multi, fs, npend, sw, auto_step, blank;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] pix_d;
  vga_onehot_enc #(.N(NUM_SRC)) u_enc (
    .onehot(bus.sel_onehot),
    .idx(req_idx),
    .ok(req_ok),
    .multi(req_multi)
  );
  assign fs = bus.pix_valid && bus.pix_x == XW'(0) && bus.pix_y == YW'(0);
  // A request landing on the frame-start cycle itself is honoured at that same boundary
  always_comb begin
    npend = req_ok ? (req_idx != cur_idx_q) : pend_q;
    npidx = req_ok ? req_idx : pend_idx_q;
    sw = fs && npend;
    pend_d = sw ? 1'b0 : npend;
    auto_idx = (cur_idx_q == IDX_W'(NUM_SRC - 1)) ? '0 : cur_idx_q + 1'b1;
    auto_step = fs && !npend && bus.auto_en && state_q != BLANK && cnt_q == CW'(AUTO_FRAMES - 1);
    eff_idx = sw ? npidx : cur_idx_q;
    nxt_idx = sw ? npidx : auto_step ? auto_idx : cur_idx_q;
    cnt_d = (!bus.auto_en || sw || auto_step || (fs && state_q == BLANK)) ? '0 :
            fs ? cnt_q + 1'b1 : cnt_q;
`ifdef VGA_PATTERN_SEL_BLANK_EN
    state_d = (sw || auto_step || (state_q == BLANK && !fs)) ? BLANK : pend_d ? PEND : SHOW;
    blank = state_d == BLANK;
`else
    state_d = pend_d ? PEND : SHOW;
    blank = 1'b0;
`endif
    pix_d = (bus.pix_valid && !blank) ? bus.src_data[eff_idx*DATA_W +: DATA_W] : DATA_W'(BLACK);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SHOW;
    else state_q <= state_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_idx_q <= IDX_W'(DEFAULT_IDX);
      pend_idx_q <= '0;
      pend_q <= 1'b0;
      cnt_q <= '0;
      bus.pix_data <= DATA_W'(BLACK);
      bus.sel_err <= 1'b0;
    end else begin
      cur_idx_q <= nxt_idx;
      pend_idx_q <= npidx;
      pend_q <= pend_d;
      cnt_q <= cnt_d;
      bus.pix_data <= pix_d;
      bus.sel_err <= req_multi;
    end
  end
  assign bus.cur_idx = cur_idx_q;
endmodule
